nios_core_rom_loader: RTL and testbench
=======================================

NIOS_CORE_ROM_LOADER -- requirements
Module: nios_core_rom_loader

Interface
REQ-001 Parameter: ADDR_W, default 12, word-address width of target memory port.
REQ-002 Parameter: DATA_W, default 32, data width of target memory port.
REQ-003 Port: clk  in  1  single clock; all logic rising-edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 Port: base_addr  in  ADDR_W  first word address; latched on accepted start.
REQ-007 Port: length  in  ADDR_W+1  word count, 0..4096; latched on accepted start.
REQ-008 Port: seed  in  DATA_W  pattern seed; latched on accepted start.
REQ-009 Port: busy  out  1  high from cycle after accepted start until done.
REQ-010 Port: done  out  1  one-cycle completion pulse.
REQ-011 Port: error  out  1  sticky mismatch flag for current/last run.
REQ-012 Port: err_count  out  ADDR_W+1  mismatch count for current/last run.
REQ-013 Port: err_addr  out  ADDR_W  address of first mismatch.
REQ-014 Ports: address out ADDR_W, chipselect out 1, write out 1, byteenable out 4, writedata out DATA_W, clken out 1, readdata in DATA_W  Avalon-MM master to one port of the on-chip RAM (fixed read latency 1, no waitrequest).

Function
REQ-015 States: IDLE, FILL, VFY, DRAIN, FIN; FIN lasts exactly one cycle.
REQ-016 IDLE + start=1 + length>0: latch operands, go FILL; length=0: go FIN, no bus access.
REQ-017 start while not IDLE SHALL be ignored.
REQ-018 FILL: one write per cycle, k=0..length-1: chipselect=1, write=1, byteenable=4'hF, address=(base_addr+k) mod 2^ADDR_W, writedata=(seed+k) mod 2^DATA_W.
REQ-019 After last write: VFY if verify compiled in, else FIN.
REQ-020 VFY: one read per cycle, same address sequence, chipselect=1, write=0; after last read go DRAIN for one cycle.
REQ-021 readdata for read k SHALL be compared in the following cycle against seed+k; last compare occurs in DRAIN.
REQ-022 Mismatch: err_count+=1, error=1; first mismatch of the run loads err_addr.
REQ-023 FIN: done=1, busy=0, then IDLE.
REQ-024 Latency, start accepted at cycle 0, N=length>0: first access cycle 1; fill-only done at cycle N+1; with verify done at cycle 2N+2; N=0 done at cycle 1.
REQ-025 Address wraps from 4095 to 0 without error.
REQ-026 error, err_count, err_addr clear on accepted start; hold after done until next start.
REQ-027 clken SHALL be 1 constantly; chipselect, write SHALL be 0 in IDLE and FIN.

Reset
REQ-028 reset=1 at any clock edge: state IDLE, any run aborted, no further access issued.
REQ-029 Reset values: busy=0, done=0, error=0, err_count=0, err_addr=0, chipselect=0, write=0, address=0, writedata=0, byteenable=4'hF, clken=1.

Configuration
REQ-030 Macro NIOS_CORE_ROM_LOADER_VERIFY_EN defined: VFY and DRAIN states and compare logic present per REQ-019..022.
REQ-031 Macro undefined: FILL goes directly to FIN; error, err_count, err_addr tied to 0; no read issued.

Verification
REQ-032 base=0x010, length=4, seed=0x1000_0000, memory model -> writes 0x010..0x013 with 0x1000_0000..0x1000_0003, done at cycle 5 (fill-only) or 10 (verify), error=0.
REQ-033 base=0xFFE, length=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
REQ-034 Verify build, model corrupts word at 0x012 after fill -> err_count=1, err_addr=0x012, error=1 at done.
REQ-035 length=0 -> done at cycle 1, chipselect never asserted, busy never asserted.
REQ-036 start pulsed again at cycle 2 of length=8 run -> ignored, single done pulse.
REQ-037 reset asserted at cycle 3 of length=8 run -> next cycle all outputs at REQ-029 values, no access afterwards; new start runs normally.

Source files
------------

// File: rtl/nios_core_rom_loader.sv
// nios_core_rom_loader: fills a RAM region with seed+k and, with NIOS_CORE_ROM_LOADER_VERIFY_EN, reads it back and counts mismatches
// Ports: clk, reset (sync active-high); start/base_addr/length/seed request a run;
// busy/done/error/err_count/err_addr report status; address/chipselect/write/byteenable/
// writedata/clken/readdata form the Avalon-MM master (read latency 1, no waitrequest).
module nios_core_rom_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  output logic              clken,
  input  logic [DATA_W-1:0] readdata
);
  typedef enum logic [2:0] {IDLE, FILL, VFY, DRAIN, FIN} state_t;
  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt;
  assign byteenable = 4'hF;
  assign clken = 1'b1;
`ifdef NIOS_CORE_ROM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] base_r;
  logic [DATA_W-1:0] seed_r;
  // pend marks a read issued last cycle whose data arrives this cycle
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_exp;
`else
  logic unused_rd;
  assign unused_rd = ^readdata;
  assign error = 1'b0;
  assign err_count = '0;
  assign err_addr = '0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      chipselect <= 1'b0;
      write <= 1'b0;
      address <= '0;
      writedata <= '0;
      len <= '0;
      cnt <= '0;
`ifdef NIOS_CORE_ROM_LOADER_VERIFY_EN
      base_r <= '0;
      seed_r <= '0;
      pend <= 1'b0;
      pend_addr <= '0;
      pend_exp <= '0;
      error <= 1'b0;
      err_count <= '0;
      err_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          len <= length;
          cnt <= 1;
          address <= base_addr;
          writedata <= seed;
`ifdef NIOS_CORE_ROM_LOADER_VERIFY_EN
          base_r <= base_addr;
          seed_r <= seed;
          error <= 1'b0;
          err_count <= '0;
          err_addr <= '0;
`endif
          if (length != '0) begin
            state <= FILL;
            busy <= 1'b1;
            chipselect <= 1'b1;
            write <= 1'b1;
          end else begin
            state <= FIN;
            done <= 1'b1;
          end
        end
        FILL: if (cnt == len) begin
`ifdef NIOS_CORE_ROM_LOADER_VERIFY_EN
          state <= VFY;
          write <= 1'b0;
          address <= base_r;
          writedata <= seed_r;
          cnt <= 1;
`else
          state <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
          chipselect <= 1'b0;
          write <= 1'b0;
`endif
        end else begin
          address <= address + 1'b1;
          writedata <= writedata + 1'b1;
          cnt <= cnt + 1'b1;
        end
`ifdef NIOS_CORE_ROM_LOADER_VERIFY_EN
        VFY: begin
          // writedata keeps stepping during reads as the expected value
          pend <= 1'b1;
          pend_addr <= address;
          pend_exp <= writedata;
          if (cnt == len) begin
            state <= DRAIN;
            chipselect <= 1'b0;
          end else begin
            address <= address + 1'b1;
            writedata <= writedata + 1'b1;
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          pend <= 1'b0;
          state <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
        end
`endif
        FIN: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef NIOS_CORE_ROM_LOADER_VERIFY_EN
      if (pend && readdata != pend_exp) begin
        error <= 1'b1;
        err_count <= err_count + 1'b1;
        if (!error) err_addr <= pend_addr;
      end
`endif
    end
endmodule

// File: tb/tb_nios_core_rom_loader.sv
// tb_nios_core_rom_loader: directed table-driven bench with a 1-cycle-latency RAM model
module tb_nios_core_rom_loader;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic [31:0] seed = '0;
  logic        busy, done, error, chipselect, write, clken;
  logic [12:0] err_count;
  logic [11:0] err_addr, address;
  logic [3:0]  byteenable;
  logic [31:0] writedata, readdata;
  logic [31:0] mem [4096];
  logic        bad_en = 0;
  logic [11:0] bad_addr = '0;
  int checks = 0, failures = 0;
  int dcyc, nw, nr;
  bit addr_ok, data_ok, busy_ok;
`ifdef NIOS_CORE_ROM_LOADER_VERIFY_EN
  localparam bit VF = 1;
`else
  localparam bit VF = 0;
`endif

  nios_core_rom_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .seed(seed), .busy(busy), .done(done), .error(error), .err_count(err_count),
    .err_addr(err_addr), .address(address), .chipselect(chipselect), .write(write),
    .byteenable(byteenable), .writedata(writedata), .clken(clken), .readdata(readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    readdata <= mem[address] ^ ((bad_en && address == bad_addr) ? 32'h1 : 32'h0);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run(input logic [11:0] b, input logic [12:0] n, input logic [31:0] s, input int restart_at);
    logic [11:0] ea;
    @(negedge clk);
    base_addr = b; length = n; seed = s; start = 1;
    @(posedge clk);
    #1 start = 0;
    dcyc = -1; nw = 0; nr = 0; addr_ok = 1; data_ok = 1; busy_ok = 1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (chipselect) begin
        if (write) begin
          ea = b + 12'(nw);
          if (address !== ea) addr_ok = 0;
          if (writedata !== s + 32'(nw)) data_ok = 0;
          nw++;
        end else begin
          ea = b + 12'(nr);
          if (address !== ea) addr_ok = 0;
          nr++;
        end
      end
      if (done) begin
        if (busy) busy_ok = 0;
        dcyc = c;
        break;
      end else if (!busy) busy_ok = 0;
    end
    start = 0;
    if (dcyc < 0) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [11:0] b;
    logic [12:0] n;
    logic [31:0] s;
    int          d_fill;
    int          d_vfy;
  } vec_t;
  vec_t tbl [4];

  initial begin
    bit mok;
    int nd, ncs;
    tbl[0] = '{12'h010, 13'd4, 32'h1000_0000, 5, 10};
    tbl[1] = '{12'hFFE, 13'd4, 32'h0000_0005, 5, 10};
    tbl[2] = '{12'h7F0, 13'd3, 32'hFFFF_FFFE, 4, 8};
    tbl[3] = '{12'h000, 13'd16, 32'hA5A5_0000, 17, 34};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_vals", {busy, done, error, err_count, err_addr, chipselect, write, address, writedata, byteenable, clken},
        {1'b0, 1'b0, 1'b0, 13'd0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0, 4'hF, 1'b1});
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      run(tbl[i].b, tbl[i].n, tbl[i].s, 0);
      chk($sformatf("done_cycle[%0d]", i), dcyc, VF ? tbl[i].d_vfy : tbl[i].d_fill);
      chk($sformatf("writes[%0d]", i), nw, tbl[i].n);
      chk($sformatf("reads[%0d]", i), nr, VF ? tbl[i].n : 0);
      chk($sformatf("addr_seq[%0d]", i), addr_ok, 1);
      chk($sformatf("wdata_seq[%0d]", i), data_ok, 1);
      chk($sformatf("busy[%0d]", i), busy_ok, 1);
      chk($sformatf("error[%0d]", i), {error, err_count}, 14'd0);
      mok = 1;
      for (int k = 0; k < int'(tbl[i].n); k++)
        if (mem[tbl[i].b + 12'(k)] !== tbl[i].s + 32'(k)) mok = 0;
      chk($sformatf("mem[%0d]", i), mok, 1);
      @(negedge clk);
      chk($sformatf("done_pulse[%0d]", i), {done, chipselect, write}, 3'b000);
    end
    // length zero: immediate done, no access, no busy
    run(12'h123, 13'd0, 32'h1, 0);
    chk("len0_done_cycle", dcyc, 1);
    chk("len0_access", nw + nr, 0);
    chk("len0_busy", busy_ok, 1);
    // corrupted readback of 0x012
    bad_addr = 12'h012; bad_en = 1;
    run(12'h010, 13'd4, 32'h1000_0000, 0);
    chk("corrupt_error", error, VF);
    chk("corrupt_count", err_count, VF ? 13'd1 : 13'd0);
    chk("corrupt_addr", err_addr, VF ? 12'h012 : 12'h000);
    bad_en = 0;
    repeat (3) @(negedge clk);
    chk("corrupt_hold", {error, err_count, err_addr}, VF ? {1'b1, 13'd1, 12'h012} : 26'd0);
    run(12'h010, 13'd4, 32'h1000_0000, 0);
    chk("error_cleared", {error, err_count}, 14'd0);
    // second start during a run is ignored
    run(12'h200, 13'd8, 32'h0000_0100, 2);
    chk("restart_done_cycle", dcyc, VF ? 18 : 9);
    chk("restart_writes", nw, 8);
    nd = 0; ncs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nd += int'(done);
      ncs += int'(chipselect);
    end
    chk("restart_single_done", nd, 0);
    chk("restart_idle_cs", ncs, 0);
    // reset in the middle of a run
    @(negedge clk);
    base_addr = 12'h300; length = 13'd8; seed = 32'h77; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrun_reset_vals", {busy, done, error, err_count, err_addr, chipselect, write, address, writedata, byteenable, clken},
        {1'b0, 1'b0, 1'b0, 13'd0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0, 4'hF, 1'b1});
    reset = 0;
    ncs = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ncs += int'(chipselect);
      nd += int'(done);
    end
    chk("post_reset_quiet", {ncs, nd}, 64'd0);
    run(12'h300, 13'd8, 32'h77, 0);
    chk("post_reset_done_cycle", dcyc, VF ? 18 : 9);
    chk("post_reset_seq", {addr_ok, data_ok, busy_ok}, 3'b111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
